// File: rtl/kf_step_ctrl.sv
// kf_step_ctrl
//   Sequencer for one iteration of the 2-state Q10 Kalman filter. It latches a
//   measurement, fires start pulses to the five serial stage blocks in order
//   (prior state || prior cov -> gain -> post state || post cov), collects
//   their done pulses and presents the posterior state on an output handshake.
//   Each stage phase has a watchdog; a timeout parks the FSM in ERR until clr.
//
// Ports
//   clk, rst_n             clock, async active-low reset
//   clr                    synchronous abort/clear
//   meas_valid/meas_ready  measurement handshake; z00_in/z10_in data
//   z00_meas/z10_meas      latched measurement
//   st_start[4:0]          start pulses: 0 prior state, 1 prior cov, 2 gain,
//                          3 post state, 4 post cov
//   st_done[4:0]           done pulses from the same stages
//   X00_post_in/X10_post_in posterior state from the post-state stage
//   x00_out/x10_out        registered posterior state
//   out_valid/out_ready    result handshake
//   busy, err, err_stage   status (err_stage: 1 PRED, 2 GAIN, 3 POST)
//   iter_cnt               completed iterations (wraps)
//
// State  | meaning
// IDLE   | waiting for a measurement
// PRED   | prior state and prior covariance stages running
// GAIN   | gain stage running
// POST   | posterior state and posterior covariance stages running
// OUT    | result held on the output until accepted
// ERR    | a phase watchdog expired; held until clr
module kf_step_ctrl #(
  parameter int N    = 20,
  parameter int FRAC = 10,
  parameter int TMO  = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                meas_valid,
  output logic                meas_ready,
  input  logic signed [N-1:0] z00_in,
  input  logic signed [N-1:0] z10_in,
  output logic signed [N-1:0] z00_meas,
  output logic signed [N-1:0] z10_meas,
  output logic        [4:0]   st_start,
  input  logic        [4:0]   st_done,
  input  logic signed [N-1:0] X00_post_in,
  input  logic signed [N-1:0] X10_post_in,
  output logic signed [N-1:0] x00_out,
  output logic signed [N-1:0] x10_out,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy,
  output logic                err,
  output logic        [1:0]   err_stage,
  output logic        [15:0]  iter_cnt
);

  // FRAC only describes the data format; no arithmetic is done here.
  generate
    if (TMO < 1 || TMO > 65535 || FRAC < 0 || FRAC >= N) begin : g_bad_param
      $error("kf_step_ctrl: TMO must be 1..65535 and FRAC must be 0..N-1");
    end
  endgenerate

  // Watchdog is a down-counter loaded on phase entry; expiry is the cycle it
  // sits at zero, which is the TMO-th cycle of the phase.
  localparam logic [15:0] WD_LOAD = 16'(TMO - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRED,
    S_GAIN,
    S_POST,
    S_OUT,
    S_ERR
  } state_t;

  state_t              state_q, state_d;
  logic        [4:0]   st_start_q, st_start_d;
  logic        [4:0]   flag_q, flag_d;
  logic                first_q, first_d;
  logic        [15:0]  wd_q, wd_d;
  logic signed [N-1:0] z00_q, z00_d, z10_q, z10_d;
  logic signed [N-1:0] x00_q, x00_d, x10_q, x10_d;
  logic                out_valid_q, out_valid_d;
  logic                err_q, err_d;
  logic        [1:0]   err_stage_q, err_stage_d;
  logic        [15:0]  iter_q, iter_d;

  logic [4:0] phase_mask;
  logic [4:0] done_v;
  logic [4:0] seen;

  always_comb begin
    phase_mask = 5'b00000;
    case (state_q)
      S_PRED:  phase_mask = 5'b00011;
      S_GAIN:  phase_mask = 5'b00100;
      S_POST:  phase_mask = 5'b11000;
      default: phase_mask = 5'b00000;
    endcase
  end

  // Done pulses only count from the cycle after the start pulse and only for
  // the stages owned by the current phase.
  assign done_v = st_done & phase_mask & {5{~first_q}};
  assign seen   = flag_q | done_v;

  always_comb begin
    state_d     = state_q;
    st_start_d  = 5'b00000;
    flag_d      = flag_q;
    first_d     = 1'b0;
    wd_d        = wd_q;
    z00_d       = z00_q;
    z10_d       = z10_q;
    x00_d       = x00_q;
    x10_d       = x10_q;
    out_valid_d = out_valid_q;
    err_d       = err_q;
    err_stage_d = err_stage_q;
    iter_d      = iter_q;

    if (clr) begin
      state_d     = S_IDLE;
      flag_d      = 5'b00000;
      wd_d        = 16'd0;
      out_valid_d = 1'b0;
      err_d       = 1'b0;
      err_stage_d = 2'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (meas_valid) begin
            z00_d      = z00_in;
            z10_d      = z10_in;
            state_d    = S_PRED;
            st_start_d = 5'b00011;
            first_d    = 1'b1;
            flag_d     = 5'b00000;
            wd_d       = WD_LOAD;
          end
        end

        S_PRED: begin
          flag_d = seen;
          if (&seen[1:0]) begin
            state_d    = S_GAIN;
            st_start_d = 5'b00100;
            first_d    = 1'b1;
            wd_d       = WD_LOAD;
          end else if (wd_q == 16'd0) begin
            state_d     = S_ERR;
            err_d       = 1'b1;
            err_stage_d = 2'd1;
          end else begin
            wd_d = wd_q - 16'd1;
          end
        end

        S_GAIN: begin
          flag_d = seen;
          if (seen[2]) begin
            state_d    = S_POST;
            st_start_d = 5'b11000;
            first_d    = 1'b1;
            wd_d       = WD_LOAD;
          end else if (wd_q == 16'd0) begin
            state_d     = S_ERR;
            err_d       = 1'b1;
            err_stage_d = 2'd2;
          end else begin
            wd_d = wd_q - 16'd1;
          end
        end

        S_POST: begin
          flag_d = seen;
          // Posterior state is only valid on the post-state done cycle.
          if (done_v[3] && !flag_q[3]) begin
            x00_d = X00_post_in;
            x10_d = X10_post_in;
          end
          if (&seen[4:3]) begin
            state_d     = S_OUT;
            out_valid_d = 1'b1;
          end else if (wd_q == 16'd0) begin
            state_d     = S_ERR;
            err_d       = 1'b1;
            err_stage_d = 2'd3;
          end else begin
            wd_d = wd_q - 16'd1;
          end
        end

        S_OUT: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            iter_d      = iter_q + 16'd1;
            state_d     = S_IDLE;
          end
        end

        S_ERR: begin
          state_d = S_ERR;
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      st_start_q  <= 5'b00000;
      flag_q      <= 5'b00000;
      first_q     <= 1'b0;
      wd_q        <= 16'd0;
      z00_q       <= '0;
      z10_q       <= '0;
      x00_q       <= '0;
      x10_q       <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      err_stage_q <= 2'd0;
      iter_q      <= 16'd0;
    end else begin
      state_q     <= state_d;
      st_start_q  <= st_start_d;
      flag_q      <= flag_d;
      first_q     <= first_d;
      wd_q        <= wd_d;
      z00_q       <= z00_d;
      z10_q       <= z10_d;
      x00_q       <= x00_d;
      x10_q       <= x10_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      err_stage_q <= err_stage_d;
      iter_q      <= iter_d;
    end
  end

  assign meas_ready = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE) && (state_q != S_ERR);
  assign st_start   = st_start_q;
  assign z00_meas   = z00_q;
  assign z10_meas   = z10_q;
  assign x00_out    = x00_q;
  assign x10_out    = x10_q;
  assign out_valid  = out_valid_q;
  assign err        = err_q;
  assign err_stage  = err_stage_q;
  assign iter_cnt   = iter_q;

endmodule
